// File: rtl/mbox_pkg.sv
// Shared types and constants for the mbox scheduler and its mbox multiply/divide unit.
package mbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } mbox_sched_state_t;

  localparam logic MBOX_OP_MUL = 1'b0;
  localparam logic MBOX_OP_DIV = 1'b1;

  localparam int MBOX_XLEN_MAX = 64;

  // Saturated result returned for a divide by zero; only the low xlen bits are set.
  function automatic logic [MBOX_XLEN_MAX-1:0] divz_result(input int xlen);
    logic [MBOX_XLEN_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < MBOX_XLEN_MAX; i++) begin
      if (i < xlen) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mbox.sv
// Single-cycle unsigned multiply/divide unit; the result is registered when en is high
// and held otherwise.
module mbox
  import mbox_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [XLEN/2-1:0] op1,
  input  logic [XLEN/2-1:0] op2,
  input  logic              mdsel,
  output logic [XLEN-1:0]   result
);

  localparam int HW = XLEN / 2;

  logic [XLEN-1:0] prod;
  logic [XLEN-1:0] quo;

  // A zero divisor yields all ones so simulation never sees X on the result.
  always_comb begin
    prod = {{(XLEN-HW){1'b0}}, op1} * {{(XLEN-HW){1'b0}}, op2};
    quo  = '1;
    if (op2 != '0) quo = {{(XLEN-HW){1'b0}}, op1 / op2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (en) begin
      result <= (mdsel == MBOX_OP_DIV) ? quo : prod;
    end
  end

endmodule

// File: rtl/mbox_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after rr_ptr, wrapping.
module mbox_rr_arb #(
  parameter  int NREQ = 4,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid
);

  logic [GW:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (idx >= (GW+1)'(NREQ)) idx = idx - (GW+1)'(NREQ);
      if (!grant_valid && req[idx[GW-1:0]]) begin
        grant[idx[GW-1:0]] = 1'b1;
        grant_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbox_sched.sv
// Shares one mbox between NREQ requesters with round-robin arbitration and valid/ready on both sides.
// Optional macro MBOX_SCHED_DIVZ_CHK_EN: short-circuits divide-by-zero requests to a saturated response.
//
// state | meaning
// IDLE  | arbitrating; req_ready driven for the winning lane
// EXEC  | latched operands at the mbox; result registered at end of cycle
// RESP  | rsp_valid[gid] held until rsp_ready[gid]
module mbox_sched
  import mbox_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREQ = 4,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0][XLEN/2-1:0]  req_op1,
  input  logic [NREQ-1:0][XLEN/2-1:0]  req_op2,
  input  logic [NREQ-1:0]              req_mdsel,
  output logic [NREQ-1:0]              rsp_valid,
  input  logic [NREQ-1:0]              rsp_ready,
  output logic [XLEN-1:0]              rsp_data,
  output logic                         rsp_divz,
  output logic                         busy
);

  mbox_sched_state_t state_q, state_d;

  logic [GW-1:0]     rr_ptr_q;
  logic [GW-1:0]     gid_q;
  logic [XLEN/2-1:0] op1_q;
  logic [XLEN/2-1:0] op2_q;
  logic              mdsel_q;

  logic [NREQ-1:0]   grant;
  logic              grant_valid;
  logic [GW-1:0]     win;
  logic              win_divz;
  logic              accept_req;
  logic              accept_rsp;
  logic [XLEN-1:0]   mbox_result;
  logic [GW-1:0]     rr_ptr_next;

  mbox_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win = GW'(i);
    end
  end

`ifdef MBOX_SCHED_DIVZ_CHK_EN
  localparam logic [XLEN-1:0] DIVZ_DATA = XLEN'(divz_result(XLEN));

  logic divz_q;

  assign win_divz = (req_mdsel[win] == MBOX_OP_DIV) && (req_op2[win] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      divz_q <= 1'b0;
    end else if (accept_req) begin
      divz_q <= win_divz;
    end
  end

  assign rsp_divz = (state_q == RESP) && !rst && divz_q;

  always_comb begin
    rsp_data = '0;
    if (state_q == RESP && !rst) rsp_data = divz_q ? DIVZ_DATA : mbox_result;
  end
`else
  assign win_divz = 1'b0;
  assign rsp_divz = 1'b0;

  always_comb begin
    rsp_data = '0;
    if (state_q == RESP && !rst) rsp_data = mbox_result;
  end
`endif

  // Every output is forced low while rst is high, even before the state register clears.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    rsp_valid  = '0;
    accept_req = 1'b0;
    accept_rsp = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            req_ready  = grant;
            accept_req = 1'b1;
            state_d    = win_divz ? RESP : EXEC;
          end
        end
        EXEC: state_d = RESP;
        RESP: begin
          rsp_valid[gid_q] = 1'b1;
          if (rsp_ready[gid_q]) begin
            accept_rsp = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rr_ptr_next = (gid_q == GW'(NREQ-1)) ? '0 : gid_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      mdsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_req) begin
        gid_q   <= win;
        op1_q   <= req_op1[win];
        op2_q   <= req_op2[win];
        mdsel_q <= req_mdsel[win];
      end
      if (accept_rsp) rr_ptr_q <= rr_ptr_next;
    end
  end

  assign busy = !rst && (state_q != IDLE);

  mbox #(
    .XLEN (XLEN)
  ) u_mbox (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == EXEC),
    .op1    (op1_q),
    .op2    (op2_q),
    .mdsel  (mdsel_q),
    .result (mbox_result)
  );

endmodule
